// File: rtl/bit_serial_alu_ctrl.sv
// bit_serial_alu_ctrl
//   Runs a 1-bit AND/OR/ADD slice over WIDTH-bit operands, LSB first, one bit
//   per clock, giving a start/busy/done multi-bit ALU.
//
// Ports
//   clk, rst     clock; asynchronous active-high reset
//   start        request, honoured only in IDLE or DONE
//   a, b         operands, latched on accept
//   ainv, binv   invert A / B before the slice, latched on accept
//   op           00=AND, 01=OR, 1x=ADD, latched on accept
//   carryin      initial carry, latched on accept
//   busy         high while the operation is running
//   done         one-cycle pulse in the cycle the result becomes valid
//   result       final result, held until the next completion
//   carryout     carry out of MSB for ADD, latched carryin for AND/OR
//   overflow     ADD only: carry into MSB xor carry out of MSB
//   zero         result == 0
//   state_dbg    current FSM state (0=IDLE, 1=RUN, 2=DONE)
//
// Handshake: a request is taken on any posedge where start=1 and the block is
// in IDLE or DONE. busy rises for exactly WIDTH cycles, then done pulses for
// one cycle with the new result. start while busy is ignored.

module bit_serial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ainv,
  input  logic             binv,
  input  logic [1:0]       op,
  input  logic             carryin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] acc;       // bits already produced, MSB-aligned
  logic [CW-1:0]    cnt;
  logic             ainv_q, binv_q, c;
  logic [1:0]       op_q;

  logic             accept, last, is_add, wa, wb, r, c_nxt;
  logic [WIDTH-1:0] res_final;

  always_comb begin
    accept    = start && (state == S_IDLE || state == S_DONE);
    last      = (cnt == LAST);
    is_add    = op_q[1];
    wa        = a_sr[0] ^ ainv_q;
    wb        = b_sr[0] ^ binv_q;
    c_nxt     = (wa & wb) | (wa & c) | (wb & c);
    r         = 1'b0;
    if (is_add)       r = wa ^ wb ^ c;
    else if (op_q[0]) r = wa | wb;
    else              r = wa & wb;
    // New bit enters at the MSB; after WIDTH steps bit 0 sits at position 0.
    res_final = {r, acc};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_RUN;
      S_RUN:   if (last)   state_nxt = S_DONE;
      S_DONE:  state_nxt = accept ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr     <= '0;
      b_sr     <= '0;
      acc      <= '0;
      cnt      <= '0;
      ainv_q   <= 1'b0;
      binv_q   <= 1'b0;
      op_q     <= 2'b00;
      c        <= 1'b0;
      result   <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (accept) begin
      a_sr   <= a;
      b_sr   <= b;
      ainv_q <= ainv;
      binv_q <= binv;
      op_q   <= op;
      c      <= carryin;
      cnt    <= '0;
      acc    <= '0;
    end else if (state == S_RUN) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      acc  <= res_final[WIDTH-1:1];
      cnt  <= cnt + CW'(1);
      if (is_add) c <= c_nxt;
      if (last) begin
        result   <= res_final;
        carryout <= is_add ? c_nxt : c;
        // c here is still the carry into the MSB.
        overflow <= is_add & (c ^ c_nxt);
        zero     <= (res_final == '0);
      end
    end
  end

  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);
  assign state_dbg = state;

endmodule
